// File: rtl/add_sub_pipe_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
// The master drives the operands and accepts results. The slave is the adder.
interface add_sub_pipe_if #(
    parameter int unsigned N = 32
);
    logic         valid_i;
    logic         ready_o;
    logic         sub_i;
    logic         cin_i;
    logic [N-1:0] data0_i;
    logic [N-1:0] data1_i;
    logic         valid_o;
    logic         ready_i;
    logic [N-1:0] sum_o;
    logic         cout_o;
    logic         ovf_o;
    logic         zero_o;

    modport master (
        output valid_i, sub_i, cin_i, data0_i, data1_i, ready_i,
        input  ready_o, valid_o, sum_o, cout_o, ovf_o, zero_o
    );

    modport slave (
        input  valid_i, sub_i, cin_i, data0_i, data1_i, ready_i,
        output ready_o, valid_o, sum_o, cout_o, ovf_o, zero_o
    );
endinterface

// File: rtl/add_sub_pipe.sv
// N-bit pipelined adder/subtractor. The carry chain is cut into STAGES equal
// slices. Each slice is resolved in its own registered stage, so one
// operation can be accepted per clock. A single global stall freezes the
// whole pipe whenever the held result has not been taken downstream.
module add_sub_pipe #(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 4
) (
    input logic           clk_i,
    input logic           rst_i,
    add_sub_pipe_if.slave bus
);
    localparam int unsigned W    = N / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    // Stage registers. Each entry holds the full operand width. Bits already
    // consumed by earlier slices are never read again.
    logic [N-1:0]      a_q [STAGES];
    logic [N-1:0]      b_q [STAGES];
    logic [N-1:0]      s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] vld_q;
    logic              ovf_q;
    logic              zero_q;

    logic [N-1:0]      a_d [STAGES];
    logic [N-1:0]      b_d [STAGES];
    logic [N-1:0]      s_d [STAGES];
    logic [STAGES-1:0] c_d;
    logic              ovf_d;
    logic              zero_d;
    logic              advance;

    function automatic logic [W:0] slice_add(
        input logic [W-1:0] x,
        input logic [W-1:0] y,
        input logic         ci
    );
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    // Global stall: move only when the output slot is empty or being taken.
    always_comb begin
        advance = bus.ready_i || !vld_q[LAST];
    end

    assign bus.ready_o = advance;
    assign bus.valid_o = vld_q[LAST];
    assign bus.sum_o   = s_q[LAST];
    assign bus.cout_o  = c_q[LAST];
    assign bus.ovf_o   = ovf_q;
    assign bus.zero_o  = zero_q;

    // Per-stage next values: stage 0 resolves slice 0 from the inputs, and
    // stage k resolves slice k from stage k-1 and its registered carry.
    always_comb begin
        a_d[0] = bus.data0_i;
        b_d[0] = bus.data1_i ^ {N{bus.sub_i}};
        s_d[0] = '0;
        {c_d[0], s_d[0][W-1:0]} = slice_add(a_d[0][W-1:0], b_d[0][W-1:0], bus.cin_i);
        for (int unsigned k = 1; k < STAGES; k++) begin
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            s_d[k] = s_q[k-1];
            {c_d[k], s_d[k][k*W +: W]} = slice_add(a_q[k-1][k*W +: W], b_q[k-1][k*W +: W], c_q[k-1]);
        end
        // Flags are registered alongside the last slice. This keeps zero_o at 0
        // during reset even though sum_o is also 0 then.
        ovf_d  = (a_d[LAST][N-1] == b_d[LAST][N-1]) && (s_d[LAST][N-1] != a_d[LAST][N-1]);
        zero_d = (s_d[LAST] == '0);
    end

    // Pipeline registers: clear on reset, shift together on advance, hold otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q    <= '0;
            vld_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            vld_q[0] <= bus.valid_i;
            for (int unsigned k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end
endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe. It uses an 8-bit/2-stage instance and a
// 32-bit/4-stage instance. Directed vector tables are checked one operation
// at a time. Hand sequences cover async reset with ops in flight,
// back-to-back throughput and a five-cycle downstream stall.
module tb_add_sub_pipe;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned total  = 0;
    int unsigned passed = 0;

    vec_t        vec8  [8];
    vec_t        vec32 [8];
    logic [31:0] op_a   [32];
    logic [31:0] op_b   [32];
    logic        op_sub [32];
    logic        op_cin [32];

    add_sub_pipe_if #(.N(8))  b8 ();
    add_sub_pipe_if #(.N(32)) b32 ();

    add_sub_pipe #(.N(8), .STAGES(2)) dut8 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b8.slave)
    );

    add_sub_pipe #(.N(32), .STAGES(4)) dut32 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b32.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                input logic cin, input logic [31:0] sum, input logic cout,
                                input logic ovf, input logic zero);
        vec_t v;
        v.a = a; v.b = b; v.sub = sub; v.cin = cin;
        v.sum = sum; v.cout = cout; v.ovf = ovf; v.zero = zero;
        return v;
    endfunction

    // Reference: modulo-2^32 sum of A, the conditionally inverted B and the carry-in.
    function automatic vec_t model32(input logic [31:0] a, input logic [31:0] b,
                                     input logic sub, input logic cin);
        logic [31:0] beff;
        logic [32:0] full;
        beff = b ^ {32{sub}};
        full = {1'b0, a} + {1'b0, beff} + {32'b0, cin};
        return mk(a, b, sub, cin, full[31:0], full[32],
                  (a[31] == beff[31]) && (full[31] != a[31]), full[31:0] == 32'd0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            op_a[i]   = $urandom;
            op_b[i]   = $urandom;
            op_sub[i] = 1'($urandom_range(0, 1));
            op_cin[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drive32(input int i);
        b32.data0_i = op_a[i];
        b32.data1_i = op_b[i];
        b32.sub_i   = op_sub[i];
        b32.cin_i   = op_cin[i];
    endtask

    task automatic run_vec8();
        int lat;
        for (int i = 0; i < 8; i++) begin
            b8.valid_i = 1'b1;
            b8.data0_i = vec8[i].a[7:0];
            b8.data1_i = vec8[i].b[7:0];
            b8.sub_i   = vec8[i].sub;
            b8.cin_i   = vec8[i].cin;
            lat = -1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (b8.valid_o) begin
                    lat = c;
                    break;
                end
                @(posedge clk); #1;
                b8.valid_i = 1'b0;
            end
            check($sformatf("v8[%0d]_latency", i), lat, 2);
            check($sformatf("v8[%0d]_sum", i), {24'd0, b8.sum_o}, vec8[i].sum);
            check($sformatf("v8[%0d]_cout", i), b8.cout_o, vec8[i].cout);
            check($sformatf("v8[%0d]_ovf", i), b8.ovf_o, vec8[i].ovf);
            check($sformatf("v8[%0d]_zero", i), b8.zero_o, vec8[i].zero);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_vec32();
        int lat;
        for (int i = 0; i < 8; i++) begin
            b32.valid_i = 1'b1;
            b32.data0_i = vec32[i].a;
            b32.data1_i = vec32[i].b;
            b32.sub_i   = vec32[i].sub;
            b32.cin_i   = vec32[i].cin;
            lat = -1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (b32.valid_o) begin
                    lat = c;
                    break;
                end
                @(posedge clk); #1;
                b32.valid_i = 1'b0;
            end
            check($sformatf("v32[%0d]_latency", i), lat, 4);
            check($sformatf("v32[%0d]_sum", i), b32.sum_o, vec32[i].sum);
            check($sformatf("v32[%0d]_cout", i), b32.cout_o, vec32[i].cout);
            check($sformatf("v32[%0d]_ovf", i), b32.ovf_o, vec32[i].ovf);
            check($sformatf("v32[%0d]_zero", i), b32.zero_o, vec32[i].zero);
            @(posedge clk); #1;
        end
    endtask

    // Drive nops operands while a sink stalls over cycles stall_lo..stall_hi.
    // Results must come out in order from cycle 4, with none lost or repeated.
    task automatic run_stream(input string tag, input int nops, input int stall_lo, input int stall_hi);
        int          p, q, first, last;
        logic [31:0] held_sum;
        logic [2:0]  held_flags;
        vec_t        e;
        p = 0; q = 0; first = -1; last = -1;
        held_sum = '0; held_flags = '0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            b32.ready_i = (cyc < stall_lo) || (cyc > stall_hi);
            b32.valid_i = (p < nops);
            if (p < nops) drive32(p);
            @(negedge clk);
            if (!b32.ready_i) begin
                check($sformatf("%s_stall_ready_c%0d", tag, cyc), b32.ready_o, 0);
                if (cyc == stall_lo) begin
                    held_sum   = b32.sum_o;
                    held_flags = {b32.cout_o, b32.ovf_o, b32.zero_o};
                end else begin
                    check($sformatf("%s_stall_sum_c%0d", tag, cyc), b32.sum_o, held_sum);
                    check($sformatf("%s_stall_flags_c%0d", tag, cyc),
                          {29'd0, b32.cout_o, b32.ovf_o, b32.zero_o}, {29'd0, held_flags});
                end
            end
            if (b32.valid_o) begin
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (b32.valid_o && b32.ready_i) begin
                if (q < nops) begin
                    e = model32(op_a[q], op_b[q], op_sub[q], op_cin[q]);
                    check($sformatf("%s_sum[%0d]", tag, q), b32.sum_o, e.sum);
                    check($sformatf("%s_cout[%0d]", tag, q), b32.cout_o, e.cout);
                    check($sformatf("%s_ovf[%0d]", tag, q), b32.ovf_o, e.ovf);
                    check($sformatf("%s_zero[%0d]", tag, q), b32.zero_o, e.zero);
                end else begin
                    total++;
                    $display("FAIL %s_extra: result #%0d delivered, required only %0d", tag, q, nops);
                end
                q++;
            end
            if (b32.valid_i && b32.ready_o) p++;
            @(posedge clk); #1;
        end
        b32.valid_i = 1'b0;
        b32.ready_i = 1'b1;
        check({tag, "_accepted"}, p, nops);
        check({tag, "_delivered"}, q, nops);
        check({tag, "_first_cycle"}, first, 4);
        check({tag, "_valid_span"}, last - first + 1, nops + (stall_hi - stall_lo + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec8[0] = mk(32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1);
        vec8[1] = mk(32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0);
        vec8[2] = mk(32'h80, 32'h01, 1'b1, 1'b1, 32'h7F, 1'b1, 1'b1, 1'b0);
        vec8[3] = mk(32'h05, 32'h07, 1'b1, 1'b1, 32'hFE, 1'b0, 1'b0, 1'b0);
        vec8[4] = mk(32'h00, 32'h00, 1'b1, 1'b1, 32'h00, 1'b1, 1'b0, 1'b1);
        vec8[5] = mk(32'h12, 32'h34, 1'b0, 1'b1, 32'h47, 1'b0, 1'b0, 1'b0);
        vec8[6] = mk(32'h80, 32'h80, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1);
        vec8[7] = mk(32'h0F, 32'hF0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 1'b1);

        vec32[0] = mk(32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        vec32[1] = mk(32'h5, 32'h7, 1'b1, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
        vec32[2] = mk(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        vec32[3] = mk(32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0);
        vec32[4] = mk(32'h000000FF, 32'h1, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
        vec32[5] = mk(32'h80000000, 32'h1, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        vec32[6] = mk(32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0);
        vec32[7] = mk(32'h00FFFF00, 32'h00000100, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0);

        rst = 1'b1;
        b8.valid_i = 1'b0;  b8.sub_i = 1'b0;  b8.cin_i = 1'b0;
        b8.data0_i = '0;    b8.data1_i = '0;  b8.ready_i = 1'b1;
        b32.valid_i = 1'b0; b32.sub_i = 1'b0; b32.cin_i = 1'b0;
        b32.data0_i = '0;   b32.data1_i = '0; b32.ready_i = 1'b1;

        #2;
        check("rst8_valid", b8.valid_o, 0);
        check("rst8_sum", {24'd0, b8.sum_o}, 0);
        check("rst8_zero", b8.zero_o, 0);
        check("rst32_valid", b32.valid_o, 0);
        check("rst32_sum", b32.sum_o, 0);
        check("rst32_flags", {29'd0, b32.cout_o, b32.ovf_o, b32.zero_o}, 0);
        check("rst32_ready", b32.ready_o, 1);

        @(posedge clk); #1;
        rst = 1'b0;

        run_vec8();
        run_vec32();

        // Three operations in flight, then an asynchronous reset mid-cycle.
        fill_random(3);
        for (int i = 0; i < 3; i++) begin
            b32.valid_i = 1'b1;
            drive32(i);
            @(posedge clk); #1;
        end
        b32.valid_i = 1'b0;
        b32.ready_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", b32.valid_o, 0);
        check("midrst_sum", b32.sum_o, 0);
        check("midrst_flags", {29'd0, b32.cout_o, b32.ovf_o, b32.zero_o}, 0);
        check("midrst_ready", b32.ready_o, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back stream starting on the first edge after reset release.
        fill_random(16);
        run_stream("thru", 16, 100, 99);

        // Full pipe, then the sink stalls for five cycles.
        fill_random(10);
        run_stream("bp", 10, 4, 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/add_sub_pipe.md
Name: add_sub_pipe

Overview:
Parametrised N-bit pipelined adder/subtractor. It is the successor to the single-cycle ripple adder. The carry chain is split into STAGES equal slices, and each slice is registered, so the block sustains one operation per clock at wide N. It adds a sub mode, an explicit carry-in, signed-overflow and zero flags, and a valid/ready handshake with backpressure. It sits in the datapath ALU between the operand latches and the writeback mux.

Parameters:
N, 32, operand/result width in bits; must be an integer multiple of STAGES.
STAGES, 4, number of pipeline slices; each slice resolves N/STAGES bits of the carry chain; latency = STAGES cycles; legal values 1..N.

Ports:
clk_i  input  1  clock; all registers update on the rising edge.
rst_i  input  1  asynchronous, active-high reset.
valid_i  input  1  input operands valid.
ready_o  output  1  block can accept an input this cycle.
sub_i  input  1  0 = add, 1 = subtract.
cin_i  input  1  carry-in (for sub, 1 = no borrow-in).
data0_i  input  N  operand A.
data1_i  input  N  operand B.
valid_o  output  1  result valid.
ready_i  input  1  downstream accepts the result.
sum_o  output  N  result.
cout_o  output  1  carry out of bit N-1.
ovf_o  output  1  two's-complement signed overflow.
zero_o  output  1  1 when sum_o == 0.

Behaviour:
- Arithmetic: the effective B is data1_i XOR {N{sub_i}}.
  - Result = A + Beff + cin_i, computed modulo 2^N.
  - Add: A+B+cin. Sub: A-B when cin_i=1, A-B-1 when cin_i=0.
  - cout_o is the raw carry out of the MSB. For sub, 1 means no borrow.
  - ovf_o = (A[N-1] == Beff[N-1]) && (sum[N-1] != A[N-1]).
- Transfer rules:
  - An input transfer occurs on a rising edge with valid_i && ready_o.
  - An output transfer occurs on a rising edge with valid_o && ready_i.
- Pipeline structure:
  - Stage k (k = 0..STAGES-1) holds a valid bit and the carry out of slice k.
  - Stage k also holds the completed low sum slices 0..k and the not-yet-used high slices of A and Beff.
  - Stage 0 captures the inputs and computes slice 0 using cin_i.
  - Stage k>0 computes slice k using the registered carry from stage k-1.
  - The final stage drives sum_o, cout_o, ovf_o and zero_o directly from registers; there is no combinational path from inputs to outputs.
- Flow control is a global stall:
  - advance = ready_i || !valid_o; ready_o = advance.
  - When advance=0, every pipeline register, including valid bits, holds its value.
  - Outputs therefore stay stable while valid_o=1 and ready_i=0.
  - When advance=1, every stage shifts by one. Stage 0's valid bit loads valid_i.
  - Bubbles (valid=0 entries) shift through; they are not collapsed.
- Latency and throughput:
  - Latency is exactly STAGES cycles from an accepted input to valid_o, with no stalls.
  - Throughput is one result per cycle when ready_i is held at 1.
  - STAGES=1 gives a single registered ripple adder.
- Result fields are don't-care when valid_o=0. They still update on advance; they are not gated.
- Reset (asynchronous, any time, including mid-operation):
  - All valid bits clear, so valid_o=0 and every in-flight operation is discarded.
  - sum_o=0, cout_o=0, ovf_o=0, zero_o=0.
  - ready_o becomes 1 immediately, because valid_o=0.
  - The first input transfer occurs on the first rising edge after rst_i deasserts.
- Simultaneous events:
  - An input accept and an output accept in the same cycle are both honoured, and the pipeline stays full.
  - valid_i with ready_o=0 is not captured. The source must hold its operands.
  - sub_i and cin_i are sampled only on input transfer.

Test Plan:
- Reset: assert rst_i mid-stream with 3 ops in flight -> valid_o=0 and sum_o=0 asynchronously; ready_o=1; none of the 3 results ever appears.
- Add wrap (N=8, STAGES=2): A=8'hFF, B=8'h01, sub=0, cin=0 -> after 2 cycles sum=8'h00, cout=1, ovf=0, zero=1.
- Signed overflow (N=8): A=8'h7F, B=8'h01, add, cin=0 -> sum=8'h80, cout=0, ovf=1, zero=0. Then A=8'h80, B=8'h01, sub, cin=1 -> sum=8'h7F, cout=1, ovf=1.
- Borrow (N=32, STAGES=4): A=5, B=7, sub, cin=1 -> sum=32'hFFFFFFFE, cout=0, ovf=0. The same operands with cin=0 -> sum=32'hFFFFFFFD.
- Throughput: 16 back-to-back random ops with ready_i=1 -> 16 consecutive valid_o cycles starting at cycle 4, matching a reference model in order.
- Backpressure: hold ready_i=0 for 5 cycles while the pipeline is full -> ready_o=0, sum_o/flags stable, no input captured. On release, results drain in order with none lost or duplicated.
